mux21_arb: RTL and testbench

- Round-robin arbiter and register stage directly upstream of the 2:1 mux datapath.
- Merges two valid/ready source streams (i0, i1) into one registered output stream.
- Generates the mux select internally and exports it as s.
- Downstream consumers see one registered word per cycle at full throughput.

---
 rtl/mux21_pkg.sv | 17 +
 rtl/mux21_rr_sel.sv | 24 ++
 rtl/mux21_arb.sv | 133 +++++++++++++
 tb/tb_mux21_arb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mux21_pkg.sv
// mux21_pkg: shared encodings for the 2:1 round-robin arbiter family.
// Holds the output-register state encoding, the select encoding and the
// reset value of the round-robin pointer.
package mux21_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic SEL_I0   = 1'b0;
    localparam logic SEL_I1   = 1'b1;

    // Pointer reset to "i1 went last" so that i0 wins the first contention.
    localparam logic LAST_RST = 1'b1;

endpackage

// File: rtl/mux21_rr_sel.sv
// mux21_rr_sel: combinational round-robin select for two requesters.
// On contention the input that did not win last time is chosen; with no
// requester the select parks on the previous winner.
module mux21_rr_sel
    import mux21_pkg::*;
(
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic s
);

    // Select the requester based on the valid pair and the last winner.
    always_comb begin
        s = last;
        case ({v1, v0})
            2'b11:   s = ~last;
            2'b01:   s = SEL_I0;
            2'b10:   s = SEL_I1;
            default: s = last;
        endcase
    end

endmodule

// File: rtl/mux21_arb.sv
// mux21_arb: round-robin merge of two valid/ready streams into a single
// registered output stream, exporting the internally generated mux select.
// Optional feature: define MUX21_ARB_CNT_EN to add saturating per-input
// accept counters (cnt0, cnt1) with a synchronous clear (cnt_clr).
module mux21_arb
    import mux21_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i0_valid,
    input  logic [W-1:0]     i0_data,
    output logic             i0_ready,
    input  logic             i1_valid,
    input  logic [W-1:0]     i1_data,
    output logic             i1_ready,
    output logic             y_valid,
    output logic [W-1:0]     y_data,
    output logic             y_src,
    input  logic             y_ready,
    output logic             s
`ifdef MUX21_ARB_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic [W-1:0]   y_data_q, y_data_d;
    logic           y_src_q, y_src_d;
    logic           can_load;
    logic           accept;
    logic [W-1:0]   mux_data;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    mux21_rr_sel u_sel (
        .v0   (i0_valid),
        .v1   (i1_valid),
        .last (last_q),
        .s    (s)
    );

    // The register can take a word when empty or when it drains this cycle.
    assign can_load = (state_q == ST_EMPTY) | y_ready;
    assign i0_ready = can_load & (s == SEL_I0);
    assign i1_ready = can_load & (s == SEL_I1);
    assign accept   = (s == SEL_I1) ? (i1_valid & i1_ready) : (i0_valid & i0_ready);

    // Behavioural 2:1 data mux driven by the arbiter select.
    assign mux_data = (s == SEL_I1) ? i1_data : i0_data;

    // Next-state for the output register FSM, payload and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        y_data_d = y_data_q;
        y_src_d  = y_src_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (y_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (accept) begin
            y_data_d = mux_data;
            y_src_d  = s;
            last_d   = s;
        end
    end

    // State and payload registers; a reset drops any held word at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            last_q   <= LAST_RST;
            y_data_q <= '0;
            y_src_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            y_data_q <= y_data_d;
            y_src_q  <= y_src_d;
        end
    end

    assign y_valid = (state_q == ST_FULL);
    assign y_data  = y_data_q;
    assign y_src   = y_src_q;

`ifdef MUX21_ARB_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             acc0, acc1;

    assign acc0 = i0_valid & i0_ready;
    assign acc1 = i1_valid & i1_ready;

    // Saturating accept counters; clear takes priority over an increment.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (acc0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + 1'b1;
            if (acc1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mux21_arb.sv
// tb_mux21_arb: directed stimulus with a scoreboard queue of expected
// {src, data} words; a negedge monitor pops and compares every transfer.
module tb_mux21_arb;

    localparam int W     = 8;
    localparam int CNT_W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i0_valid, i1_valid, y_ready;
    logic [W-1:0] i0_data, i1_data;
    logic         i0_ready, i1_ready, y_valid, y_src, s;
    logic [W-1:0] y_data;
`ifdef MUX21_ARB_CNT_EN
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt0, cnt1;
`endif

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    mux21_arb #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i0_valid (i0_valid),
        .i0_data  (i0_data),
        .i0_ready (i0_ready),
        .i1_valid (i1_valid),
        .i1_data  (i1_data),
        .i1_ready (i1_ready),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_src    (y_src),
        .y_ready  (y_ready),
        .s        (s)
`ifdef MUX21_ARB_CNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic [W-1:0] d);
        exp_q.push_back({src, d});
    endtask

    // Monitor: every transfer (y_valid & y_ready) must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_exclusive", {31'd0, i0_ready & i1_ready}, 32'd0);
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer actual src=%0d data=%0h required=none", y_src, y_data);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    $display("xfer src=%0d data=%02h expected src=%0d data=%02h", y_src, y_data, e[W], e[W-1:0]);
                    chk("xfer_data", {24'd0, y_data}, {24'd0, e[W-1:0]});
                    chk("xfer_src", {31'd0, y_src}, {31'd0, e[W]});
                end
            end
        end
    end

    initial begin
        logic a0, a1;
        rst_n = 1'b0; i0_valid = 0; i1_valid = 0; y_ready = 0;
        i0_data = '0; i1_data = '0;
`ifdef MUX21_ARB_CNT_EN
        cnt_clr = 1'b0;
`endif
        // Reset then idle.
        repeat (3) tick();
        chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
        chk("rst_y_data", {24'd0, y_data}, 32'd0);
        chk("rst_y_src", {31'd0, y_src}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_s", {31'd0, s}, 32'd1);
        chk("idle_i0_ready", {31'd0, i0_ready}, 32'd0);
        y_ready = 1'b1;
        tick();

        // Single source i0.
        i0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i0_data = 8'h11 * (k + 1);
            push(1'b0, 8'h11 * (k + 1));
            #1 chk("single_i1_ready", {31'd0, i1_ready}, 32'd0);
            tick();
        end
        i0_valid = 1'b0;
        tick();

        // One i1 word so the pointer says i1 went last.
        i1_valid = 1'b1; i1_data = 8'h44; push(1'b1, 8'h44);
        tick();

        // Contention: alternation starting with i0.
        i0_valid = 1'b1; i0_data = 8'hA0; i1_data = 8'hB0;
        push(0, 8'hA0); push(1, 8'hB0); push(0, 8'hA1);
        push(1, 8'hB1); push(0, 8'hA2); push(1, 8'hB2);
        for (int k = 0; k < 6; k++) begin
            #1;
            a0 = i0_ready; a1 = i1_ready;
            tick();
            if (a0) i0_data = i0_data + 1'b1;
            if (a1) i1_data = i1_data + 1'b1;
        end
        i0_valid = 1'b0; i1_valid = 1'b0;
        tick();

        // Backpressure: load 0x5A, stall 4 cycles with both inputs valid.
        y_ready = 1'b0;
        i0_valid = 1'b1; i0_data = 8'h5A; push(0, 8'h5A);
        tick();
        i0_data = 8'h5B; i1_valid = 1'b1; i1_data = 8'h6B;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_y_valid", {31'd0, y_valid}, 32'd1);
            chk("bp_y_data", {24'd0, y_data}, 32'h5A);
            chk("bp_readies", {30'd0, i1_ready, i0_ready}, 32'd0);
            tick();
        end
        y_ready = 1'b1; push(1, 8'h6B);
        tick();
        chk("nobubble_y_valid", {31'd0, y_valid}, 32'd1);
        chk("nobubble_y_data", {24'd0, y_data}, 32'h6B);
        i1_valid = 1'b0; push(0, 8'h5B);
        tick();
        i0_valid = 1'b0;
        tick();
        tick();

        // Async reset mid-stream while FULL (held word is discarded).
        y_ready = 1'b0;
        i0_valid = 1'b1; i0_data = 8'h77;
        tick();
        i0_valid = 1'b0;
        #1 chk("pre_rst_y_valid", {31'd0, y_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_y_valid", {31'd0, y_valid}, 32'd0);
        chk("async_rst_y_data", {24'd0, y_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        y_ready = 1'b1;
        i0_valid = 1'b1; i0_data = 8'hC0; i1_valid = 1'b1; i1_data = 8'hD0;
        #1;
        chk("post_rst_s", {31'd0, s}, 32'd0);
        chk("post_rst_i0_ready", {31'd0, i0_ready}, 32'd1);
        push(0, 8'hC0);
        tick();
        i0_valid = 1'b0; push(1, 8'hD0);
        tick();
        i1_valid = 1'b0;
        tick();

`ifdef MUX21_ARB_CNT_EN
        // Counter saturation and clear-over-increment.
        i1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i1_data = 8'hE0 + 8'(k); push(1, 8'hE0 + 8'(k));
            tick();
        end
        chk("cnt1_sat", {30'd0, cnt1}, 32'd3);
        cnt_clr = 1'b1; i1_data = 8'hEF; push(1, 8'hEF);
        tick();
        cnt_clr = 1'b0; i1_valid = 1'b0;
        chk("cnt1_clr", {30'd0, cnt1}, 32'd0);
        chk("cnt0_clr", {30'd0, cnt0}, 32'd0);
        tick();
`endif

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
